// File: rtl/traffic_lamp_guard.sv
// traffic_lamp_guard: safety monitor between the traffic-light FSM and the
// signal heads. Decodes the two 2-bit light codes into one-hot lamps, latches
// a fault on conflict / invalid code / illegal transition, flashes both heads
// red while faulted, and holds an all-red startup interval after reset and
// after every fault clear.
module traffic_lamp_guard #(
  parameter int unsigned STARTUP_CYCLES = 4,
  parameter int unsigned FLASH_DIV      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] ns_light_i,
  input  logic [1:0] ew_light_i,
  input  logic       clear_fault_i,
  output logic [2:0] ns_lamp_o,
  output logic [2:0] ew_lamp_o,
  output logic       fault_o,
  output logic [2:0] fault_code_o,
  output logic [7:0] fault_count_o
);

  localparam int unsigned SCW = $clog2(STARTUP_CYCLES + 1);
  localparam int unsigned FCW = $clog2(FLASH_DIV + 1);
  localparam logic [SCW-1:0] START_LAST = SCW'(STARTUP_CYCLES - 1);
  localparam logic [FCW-1:0] FLASH_LAST = FCW'(FLASH_DIV - 1);

  localparam logic [1:0] CODE_RED    = 2'b00;
  localparam logic [1:0] CODE_YELLOW = 2'b01;
  localparam logic [1:0] CODE_GREEN  = 2'b10;
  localparam logic [1:0] CODE_BAD    = 2'b11;

  // Lamp vectors are {red, yellow, green}.
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_OFF    = 3'b000;

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_NORMAL  = 2'd1,
    ST_FAULT   = 2'd2
  } state_e;

  state_e           state_q;
  logic [1:0]       ns_q, ew_q;
  logic [SCW-1:0]   start_cnt_q;
  logic [FCW-1:0]   flash_cnt_q;
  logic             flash_on_q;
  logic [2:0]       ns_lamp_q, ew_lamp_q;
  logic             fault_q;
  logic [2:0]       fault_code_q;
  logic [7:0]       fault_count_q;

  logic             conflict, invalid, illegal, viol;

  // A step involving the invalid code is reported only as invalid, never as
  // an illegal transition.
  function automatic logic illegal_step(input logic [1:0] prev, input logic [1:0] cur);
    logic bad;
    bad = 1'b1;
    if (prev == CODE_BAD || cur == CODE_BAD) begin
      bad = 1'b0;
    end else begin
      unique case ({prev, cur})
        {CODE_RED,    CODE_RED},
        {CODE_RED,    CODE_GREEN},
        {CODE_GREEN,  CODE_GREEN},
        {CODE_GREEN,  CODE_YELLOW},
        {CODE_YELLOW, CODE_YELLOW},
        {CODE_YELLOW, CODE_RED}:  bad = 1'b0;
        default:                  bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

  function automatic logic [2:0] decode(input logic [1:0] code);
    logic [2:0] lamp;
    unique case (code)
      CODE_YELLOW: lamp = LAMP_YELLOW;
      CODE_GREEN:  lamp = LAMP_GREEN;
      default:     lamp = LAMP_RED;
    endcase
    return lamp;
  endfunction

  // Safety checks on the current codes against the previous-cycle samples.
  always_comb begin
    // NOTE: every signal written here gets a value on every path; a missing
    // default would infer a latch.
    conflict = 1'b0;
    invalid  = 1'b0;
    illegal  = 1'b0;
    conflict = (ns_light_i != CODE_RED) && (ew_light_i != CODE_RED);
    invalid  = (ns_light_i == CODE_BAD) || (ew_light_i == CODE_BAD);
    illegal  = illegal_step(ns_q, ns_light_i) || illegal_step(ew_q, ew_light_i);
    viol     = conflict | invalid | illegal;
  end

  // Guard FSM with registered lamp and fault outputs.
  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every register, including the fault history, is cleared by the
      // asynchronous reset so the heads show red immediately.
      state_q       <= ST_STARTUP;
      ns_q          <= CODE_RED;
      ew_q          <= CODE_RED;
      start_cnt_q   <= '0;
      flash_cnt_q   <= '0;
      flash_on_q    <= 1'b0;
      ns_lamp_q     <= LAMP_RED;
      ew_lamp_q     <= LAMP_RED;
      fault_q       <= 1'b0;
      fault_code_q  <= 3'b000;
      fault_count_q <= 8'd0;
    end else begin
      // Previous samples track the inputs in every state so the first NORMAL
      // cycle compares against real history.
      ns_q <= ns_light_i;
      ew_q <= ew_light_i;
      unique case (state_q)
        ST_STARTUP: begin
          ns_lamp_q <= LAMP_RED;
          ew_lamp_q <= LAMP_RED;
          if (start_cnt_q == START_LAST) begin
            state_q     <= ST_NORMAL;
            start_cnt_q <= '0;
          end else begin
            start_cnt_q <= start_cnt_q + SCW'(1);
          end
        end
        ST_NORMAL: begin
          if (viol) begin
            state_q      <= ST_FAULT;
            fault_q      <= 1'b1;
            fault_code_q <= {illegal, invalid, conflict};
            if (fault_count_q != 8'hFF) fault_count_q <= fault_count_q + 8'd1;
            ns_lamp_q    <= LAMP_RED;
            ew_lamp_q    <= LAMP_RED;
            flash_on_q   <= 1'b1;
            flash_cnt_q  <= '0;
          end else begin
            ns_lamp_q <= decode(ns_light_i);
            ew_lamp_q <= decode(ew_light_i);
          end
        end
        ST_FAULT: begin
          if (clear_fault_i && !viol) begin
            state_q      <= ST_STARTUP;
            fault_q      <= 1'b0;
            fault_code_q <= 3'b000;
            start_cnt_q  <= '0;
            ns_lamp_q    <= LAMP_RED;
            ew_lamp_q    <= LAMP_RED;
          end else if (flash_cnt_q == FLASH_LAST) begin
            // Lamps are driven from the new flash phase so the change lands
            // on the same edge as the toggle.
            flash_cnt_q <= '0;
            flash_on_q  <= ~flash_on_q;
            ns_lamp_q   <= flash_on_q ? LAMP_OFF : LAMP_RED;
            ew_lamp_q   <= flash_on_q ? LAMP_OFF : LAMP_RED;
          end else begin
            flash_cnt_q <= flash_cnt_q + FCW'(1);
          end
        end
        default: state_q <= ST_STARTUP;
      endcase
    end
  end

  assign ns_lamp_o     = ns_lamp_q;
  assign ew_lamp_o     = ew_lamp_q;
  assign fault_o       = fault_q;
  assign fault_code_o  = fault_code_q;
  assign fault_count_o = fault_count_q;

endmodule

// File: tb/tb_traffic_lamp_guard.sv
// Directed self-checking bench for traffic_lamp_guard (STARTUP_CYCLES=4,
// FLASH_DIV=8). Inputs change 1 time unit after a rising edge; outputs are
// sampled 1 time unit after the next rising edge.
module tb_traffic_lamp_guard;

  logic       clk;
  logic       rst_n;
  logic [1:0] ns_light, ew_light;
  logic       clear_fault;
  logic [2:0] ns_lamp, ew_lamp;
  logic       fault;
  logic [2:0] fault_code;
  logic [7:0] fault_count;

  int tests_run    = 0;
  int tests_failed = 0;

  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001, O = 3'b000;

  traffic_lamp_guard #(.STARTUP_CYCLES(4), .FLASH_DIV(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ns_light_i    (ns_light),
    .ew_light_i    (ew_light),
    .clear_fault_i (clear_fault),
    .ns_lamp_o     (ns_lamp),
    .ew_lamp_o     (ew_lamp),
    .fault_o       (fault),
    .fault_code_o  (fault_code),
    .fault_count_o (fault_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [2:0] ns_e, input logic [2:0] ew_e,
                           input logic flt_e);
    check({tag, ".ns"},    32'(ns_lamp), 32'(ns_e));
    check({tag, ".ew"},    32'(ew_lamp), 32'(ew_e));
    check({tag, ".fault"}, 32'(fault),   32'(flt_e));
  endtask

  // Apply one input vector for exactly one clock cycle.
  task automatic cyc(input logic [1:0] ns, input logic [1:0] ew, input logic clr);
    ns_light    = ns;
    ew_light    = ew;
    clear_fault = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic startup4(input string tag);
    for (int i = 0; i < 4; i++) begin
      cyc(2'b00, 2'b00, 1'b0);
      check_out(tag, R, R, 1'b0);
    end
  endtask

  logic [1:0] seq_ns [4] = '{2'b10, 2'b01, 2'b00, 2'b00};
  logic [1:0] seq_ew [4] = '{2'b00, 2'b00, 2'b10, 2'b01};
  logic [2:0] exp_ns [4] = '{G, Y, R, R};
  logic [2:0] exp_ew [4] = '{R, R, G, Y};
  int exp_count;

  initial begin
    rst_n = 1'b0; ns_light = 2'b00; ew_light = 2'b00; clear_fault = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", R, R, 1'b0);
    check("reset.code",  32'(fault_code),  32'd0);
    check("reset.count", 32'(fault_count), 32'd0);
    rst_n = 1'b1;

    // Startup while upstream cycles, then lamps follow with one-cycle lag.
    for (int i = 0; i < 4; i++) begin
      cyc(seq_ns[i], seq_ew[i], 1'b0);
      check_out("startup", R, R, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(seq_ns[i], seq_ew[i], 1'b0);
      check_out("follow", exp_ns[i], exp_ew[i], 1'b0);
    end

    // Conflict fault and flash timing.
    cyc(2'b00, 2'b00, 1'b0);
    check_out("allred", R, R, 1'b0);
    cyc(2'b10, 2'b10, 1'b0);
    check_out("conflict", R, R, 1'b1);
    check("conflict.code",  32'(fault_code),  32'b001);
    check("conflict.count", 32'(fault_count), 32'd1);
    for (int i = 0; i < 7; i++) cyc(2'b00, 2'b00, 1'b0);
    check_out("flash7", R, R, 1'b1);
    cyc(2'b00, 2'b00, 1'b0);
    check_out("flash8", O, O, 1'b1);
    for (int i = 0; i < 7; i++) cyc(2'b00, 2'b00, 1'b0);
    check_out("flash15", O, O, 1'b1);
    cyc(2'b00, 2'b00, 1'b0);
    check_out("flash16", R, R, 1'b1);

    // Clear while still violating is ignored; new violation not recorded.
    cyc(2'b10, 2'b10, 1'b1);
    check_out("clr_viol", R, R, 1'b1);
    check("clr_viol.code", 32'(fault_code), 32'b001);
    cyc(2'b00, 2'b00, 1'b0);
    cyc(2'b00, 2'b00, 1'b1);
    check_out("clear", R, R, 1'b0);
    check("clear.code", 32'(fault_code), 32'd0);
    startup4("clr_startup");
    cyc(2'b10, 2'b00, 1'b0);
    check_out("clr_follow", G, R, 1'b0);

    // Invalid code after a legal red->red step.
    cyc(2'b01, 2'b00, 1'b0);
    check_out("yel", Y, R, 1'b0);
    cyc(2'b00, 2'b00, 1'b0);
    cyc(2'b00, 2'b00, 1'b0);
    check_out("redred", R, R, 1'b0);
    cyc(2'b11, 2'b00, 1'b0);
    check("invalid.code",  32'(fault_code),  32'b010);
    check("invalid.count", 32'(fault_count), 32'd2);
    check_out("invalid", R, R, 1'b1);
    cyc(2'b00, 2'b00, 1'b1);
    check("inv_clear.fault", 32'(fault), 32'd0);
    startup4("inv_startup");

    // Illegal green->red.
    cyc(2'b10, 2'b00, 1'b0);
    check_out("green", G, R, 1'b0);
    cyc(2'b00, 2'b00, 1'b0);
    check("illegal.code",  32'(fault_code),  32'b100);
    check("illegal.count", 32'(fault_count), 32'd3);
    for (int i = 0; i < 10; i++) cyc(2'b00, 2'b00, 1'b0);
    check_out("midflash", O, O, 1'b1);

    // Asynchronous reset mid-flash.
    #2 rst_n = 1'b0;
    #1;
    check_out("async_rst", R, R, 1'b0);
    check("async_rst.code",  32'(fault_code),  32'd0);
    check("async_rst.count", 32'(fault_count), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    startup4("rst_startup");

    // clear_fault in NORMAL has no effect; then conflict + invalid together.
    cyc(2'b00, 2'b10, 1'b1);
    check_out("normal_clr", R, G, 1'b0);
    cyc(2'b11, 2'b10, 1'b0);
    check("combo.code",  32'(fault_code),  32'b011);
    check("combo.count", 32'(fault_count), 32'd1);

    // Saturation of the fault counter.
    exp_count = 1;
    for (int n = 0; n < 256; n++) begin
      cyc(2'b01, 2'b01, 1'b0);
      cyc(2'b00, 2'b00, 1'b1);
      repeat (4) cyc(2'b00, 2'b00, 1'b0);
      cyc(2'b10, 2'b10, 1'b0);
      exp_count = (exp_count < 255) ? exp_count + 1 : 255;
      if (n == 253) check("count254", 32'(fault_count), 32'(exp_count));
    end
    check("sat.count", 32'(fault_count), 32'd255);
    check("sat.fault", 32'(fault), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
